// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter with parity, 1/2 stop bits and break
module uart_tx_cfg #(
    parameter int DBIT_MAX = 8,
    parameter int OVS      = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         s_tick,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    input  logic [DBIT_MAX-1:0]          tx_data,
    input  logic [$clog2(DBIT_MAX+1)-1:0] cfg_len,
    input  logic [1:0]                   cfg_par,
    input  logic                         cfg_stop2,
    input  logic                         send_break,
    output logic                         tx_busy,
    output logic                         tx_done_tick,
    output logic                         tx
);
    localparam int LW = $clog2(DBIT_MAX + 1);
    localparam int TW = $clog2(2 * OVS);
    localparam logic [TW-1:0] BIT_LAST   = TW'(OVS - 1);
    localparam logic [TW-1:0] STOP2_LAST = TW'(2 * OVS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic [LW-1:0]       bit_q, bit_d;
    logic [LW-1:0]       len_q, len_d;
    logic [DBIT_MAX-1:0] sh_q, sh_d;
    logic [1:0]          par_q, par_d;
    logic                stop2_q, stop2_d;
    logic                brk_q, brk_d;
    logic                pacc_q, pacc_d;
    logic                tx_q, tx_d;
    logic [LW-1:0]       len_clamped;
    logic [TW-1:0]       stop_last;

    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len < LW'(5))
            len_clamped = LW'(5);
        else if (cfg_len > LW'(DBIT_MAX))
            len_clamped = LW'(DBIT_MAX);
    end

    // A mark-after-break clears stop2_q, so it always lasts one bit time.
    assign stop_last = stop2_q ? STOP2_LAST : BIT_LAST;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            len_q   <= LW'(DBIT_MAX);
            sh_q    <= '0;
            par_q   <= '0;
            stop2_q <= 1'b0;
            brk_q   <= 1'b0;
            pacc_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            len_q   <= len_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            stop2_q <= stop2_d;
            brk_q   <= brk_d;
            pacc_q  <= pacc_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        bit_d        = bit_q;
        len_d        = len_q;
        sh_d         = sh_q;
        par_d        = par_q;
        stop2_d      = stop2_q;
        brk_d        = brk_q;
        pacc_d       = pacc_q;
        tx_d         = tx_q;
        tx_ready     = 1'b0;
        tx_done_tick = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d     = 1'b1;
                tx_ready = !send_break;
                if (send_break) begin
                    state_d = BREAK;
                    tx_d    = 1'b0;
                end else if (tx_valid) begin
                    state_d = START;
                    tx_d    = 1'b0;
                    sh_d    = tx_data;
                    len_d   = len_clamped;
                    par_d   = cfg_par;
                    stop2_d = cfg_stop2;
                    brk_d   = 1'b0;
                    pacc_d  = 1'b0;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_q == BIT_LAST) begin
                        tick_d  = '0;
                        state_d = DATA;
                        tx_d    = sh_q[0];
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_q == BIT_LAST) begin
                        tick_d = '0;
                        sh_d   = sh_q >> 1;
                        pacc_d = pacc_q ^ sh_q[0];
                        if (bit_q == len_q - LW'(1)) begin
                            bit_d = '0;
                            if (par_q[0] ^ par_q[1]) begin
                                state_d = PARITY;
                                tx_d    = pacc_q ^ sh_q[0] ^ par_q[1];
                            end else begin
                                state_d = STOP;
                                tx_d    = 1'b1;
                            end
                        end else begin
                            bit_d = bit_q + LW'(1);
                            tx_d  = sh_q[1];
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (tick_q == BIT_LAST) begin
                        tick_d  = '0;
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (s_tick) begin
                    if (tick_q == stop_last) begin
                        tick_d       = '0;
                        state_d      = IDLE;
                        tx_done_tick = !brk_q;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            BREAK: begin
                tx_d = 1'b0;
                if (!send_break) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    tick_d  = '0;
                    stop2_d = 1'b0;
                    brk_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                tick_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    assign tx_busy = (state_q != IDLE);
    assign tx      = tx_q;

endmodule
